uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Serial receiver paired with UART_TX: consumes the idle-high 8N1-style line UART_TX drives.
//   Recovers one frame (start, BITS data LSB-first, one stop) per character.
//   Presents each character on a parallel bus with a valid/ack handshake.
//   Reports framing errors and overruns.
// PARAMETERS
//   BITS          8   data bits per frame
//   CLKS_PER_BIT  16  clk cycles per bit period; even, >= 4
// PORTS
//   clk         in   1     system clock; all logic on rising edge
//   rst         in   1     synchronous, active-low reset (sampled on clk rising edge)
//   rx          in   1     asynchronous serial line, idle high
//   data        out  BITS  last received character, LSB = first data bit on line
//   data_valid  out  1     high while data holds an unacknowledged character
//   data_ack    in   1     consumer accepts data; effective only when data_valid=1
//   frame_err   out  1     1-cycle pulse: stop bit sampled low
//   overrun     out  1     1-cycle pulse: character completed while data_valid=1, new char dropped
//   busy        out  1     high whenever state != IDLE
// BEHAVIOUR
//   Reset (rst=0 at clk edge)
//     - data=0, data_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, counters=0.
//     - Both sync flops and the edge-detect register are set to 1.
//     - Reset mid-frame abandons the frame; no pulse is emitted.
//   Input synchronisation
//     - rx passes through 2 flops to give rx_s. rx_prev holds rx_s from the previous cycle.
//   Start detect
//     - Occurs in IDLE when rx_s=0 and rx_prev=1 (falling edge only).
//     - A line held low, e.g. after reset or after a break, never retriggers.
//   FSM: IDLE -> START -> DATA -> STOP -> IDLE
//     - cnt clears on every state entry and increments each cycle.
//     - START: at cnt = CLKS_PER_BIT/2-1, sample rx_s. 0 -> DATA. 1 -> IDLE (glitch rejected, no pulse).
//     - DATA: at cnt = CLKS_PER_BIT-1, shift rx_s into shreg MSB (right-shift, LSB-first).
//       After BITS samples -> STOP.
//     - STOP: at cnt = CLKS_PER_BIT-1, sample rx_s, then -> IDLE.
//       1: deliver the character. 0: pulse frame_err and discard shreg.
//   Latency
//     - Stop sample occurs CLKS_PER_BIT/2 + (BITS+1)*CLKS_PER_BIT cycles after START entry.
//     - data/data_valid update on the next edge.
//   Deliver rules
//     - data_valid=0: data <= shreg, data_valid <= 1.
//     - data_valid=1 and data_ack=1 in the same cycle: load the new char, data_valid stays 1, no overrun.
//     - data_valid=1 and data_ack=0: data unchanged, overrun pulses for 1 cycle.
//   Handshake
//     - data_ack with data_valid=1 and no delivery: data_valid <= 0 next edge; data retains its value.
//     - data_ack with data_valid=0: ignored.
//   Pulses
//     - frame_err and overrun are high exactly one cycle, and never together.
//   Widths
//     - cnt is $clog2(CLKS_PER_BIT) bits; bit index is $clog2(BITS+1) bits.
//     - No wrap: each counter clears on state change.
// STRUCTURE
//   - Shared header uart_defs.vh: FSM state localparams (IDLE, START, DATA, STOP, 2-bit encoding).
//     Also BITS and CLKS_PER_BIT defaults, so UART_TX and uart_rx agree on frame format.
//   - One sub-module: sync_2ff (2-flop synchroniser, reset value parameterised, here 1).
//   - FSM, counters, shift register and output register all live in uart_rx.
// TESTING (BITS=8, CLKS_PER_BIT=16, clk period 2)
//   1. Frame 0x5C, stop=1, data_ack held 0
//      -> data=0x5C, data_valid=1 at stop sample+1, frame_err=0, busy falls at the same edge.
//   2. Two back-to-back frames 0xA5 then 0x3C, data_ack pulsed 1 cycle between them
//      -> data 0xA5 then 0x3C, no overrun.
//   3. Frame 0x81 with stop bit driven 0
//      -> frame_err 1-cycle pulse, data_valid stays 0, rx held low afterwards causes no new START.
//   4. Low glitch of 4 cycles on idle line -> START entered, returns to IDLE, no outputs change.
//   5. Two frames (0x11, 0x22), no data_ack
//      -> data=0x11 stays, overrun pulses once at the 2nd stop sample.
//      Repeat with data_ack asserted on that exact cycle -> data=0x22, no overrun.
//   6. rst=0 asserted mid-DATA of frame 0xFF -> all outputs 0 next edge.
//      A following clean frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Frame-format defaults and FSM state encoding shared by the
//               UART transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int c_DEF_BITS         = 8;
    localparam int c_DEF_CLKS_PER_BIT = 16;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync_2ff
// Description : Two-flop synchroniser with active-low synchronous reset and a
//               parameterised reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : uart_rx_sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1-style serial receiver with valid/ack output register,
//               framing-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BITS         = c_DEF_BITS,
    parameter int CLKS_PER_BIT = c_DEF_CLKS_PER_BIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    output logic [BITS-1:0] data,
    output logic            data_valid,
    input  logic            data_ack,
    output logic            frame_err,
    output logic            overrun,
    output logic            busy
);

    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam int c_BW = $clog2(BITS + 1);
    localparam logic [c_CW-1:0] c_HALF_M1  = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_FULL_M1  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(BITS - 1);

    logic            w_rx_s;
    logic            r_rx_prev;
    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [c_CW-1:0] r_cnt;
    logic [c_BW-1:0] r_bit_idx;
    logic [BITS-1:0] r_shreg;
    logic [BITS-1:0] r_data;
    logic            r_data_valid;
    logic            r_frame_err;
    logic            r_overrun;
    logic            w_busy;
    logic            w_cnt_full;
    logic            w_stop_sample;

    uart_rx_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (w_rx_s)
    );

    assign w_cnt_full    = (r_cnt == c_FULL_M1);
    assign w_stop_sample = (r_state == c_ST_STOP) && w_cnt_full;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_ST_IDLE;
            r_rx_prev <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_rx_prev <= w_rx_s;
        end
    end

    // Next-state logic; only a falling edge starts a frame, so a held-low line is ignored
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (!w_rx_s && r_rx_prev) w_state_next = c_ST_START;
            c_ST_START: if (r_cnt == c_HALF_M1) w_state_next = w_rx_s ? c_ST_IDLE : c_ST_DATA;
            c_ST_DATA:  if (w_cnt_full && (r_bit_idx == c_LAST_BIT)) w_state_next = c_ST_STOP;
            c_ST_STOP:  if (w_cnt_full) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy = (r_state != c_ST_IDLE);
    end

    // Bit-period counter, bit index and shift register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else begin
            if ((w_state_next != r_state) || (r_state == c_ST_IDLE))
                r_cnt <= '0;
            else if ((r_state == c_ST_DATA) && w_cnt_full)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + c_CW'(1);

            if (w_state_next != r_state)
                r_bit_idx <= '0;
            else if ((r_state == c_ST_DATA) && w_cnt_full)
                r_bit_idx <= r_bit_idx + c_BW'(1);

            if ((r_state == c_ST_DATA) && w_cnt_full)
                r_shreg <= {w_rx_s, r_shreg[BITS-1:1]};
        end
    end

    // Output register: a same-cycle ack frees the slot for the arriving character
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (w_stop_sample && !w_rx_s) begin
                r_frame_err <= 1'b1;
                if (data_ack)
                    r_data_valid <= 1'b0;
            end else if (w_stop_sample) begin
                if (!r_data_valid || data_ack) begin
                    r_data       <= r_shreg;
                    r_data_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (data_ack) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = w_busy;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Scoreboard testbench for uart_rx (BITS=8, CLKS_PER_BIT=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_cmp;
    int n_err;
    int n_ferr;
    int n_ovr;
    int n_busy_rise;
    logic [7:0] exp_q[$];

    logic       r_prev_dv;
    logic [7:0] r_prev_data;
    logic       r_prev_ferr;
    logic       r_prev_ovr;
    logic       r_prev_busy;

    uart_rx #(
        .BITS         (8),
        .CLKS_PER_BIT (c_CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor: a load is data_valid rising, or data changing while valid
    initial begin
        r_prev_dv = 1'b0; r_prev_data = '0; r_prev_ferr = 1'b0;
        r_prev_ovr = 1'b0; r_prev_busy = 1'b0;
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (data_valid && (!r_prev_dv || data != r_prev_data)) begin
                if (exp_q.size() == 0)
                    check("unexpected_char", {24'd0, data}, 32'hFFFF_FFFF);
                else
                    check("data", {24'd0, data}, {24'd0, exp_q.pop_front()});
                check("busy_at_load", {31'd0, busy}, 32'd0);
            end
            if (frame_err || overrun)
                check("pulse_exclusive", {31'd0, frame_err & overrun}, 32'd0);
            if (frame_err) begin
                check("ferr_width", {31'd0, r_prev_ferr}, 32'd0);
                n_ferr++;
            end
            if (overrun) begin
                check("ovr_width", {31'd0, r_prev_ovr}, 32'd0);
                n_ovr++;
            end
            if (busy && !r_prev_busy) n_busy_rise++;
        end
        r_prev_dv   = data_valid;
        r_prev_data = data;
        r_prev_ferr = frame_err;
        r_prev_ovr  = overrun;
        r_prev_busy = busy;
    end

    // Drives the first n_cyc cycles of a frame; optionally raises ack so it is
    // seen on the edge that samples the stop bit (3 cycles sync/detect + 8 + 9*16)
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit ack_at_stop, input int n_cyc);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk);
            if (c % c_CPB == 0) rx = f[c / c_CPB];
            if (ack_at_stop) data_ack = (c == 154);
        end
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        data_ack = 1'b1;
        @(posedge clk);
        data_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    int ferr0, ovr0, busy0;

    initial begin
        n_cmp = 0; n_err = 0; n_ferr = 0; n_ovr = 0; n_busy_rise = 0;
        rst = 1'b0; rx = 1'b1; data_ack = 1'b0;
        idle(4);
        @(negedge clk);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        idle(10);

        // 1: single frame, no ack
        exp_q.push_back(8'h5C);
        send_frame(8'h5C, 1'b1, 1'b0, 10 * c_CPB);
        wait_drain("t1");
        @(negedge clk);
        check("t1_valid", {31'd0, data_valid}, 32'd1);
        check("t1_data", {24'd0, data}, 32'h5C);
        check("t1_ferr_cnt", n_ferr, 0);
        ack_pulse();
        @(negedge clk);
        check("t1_valid_after_ack", {31'd0, data_valid}, 32'd0);
        check("t1_data_retained", {24'd0, data}, 32'h5C);

        // 2: back-to-back with ack between
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 10 * c_CPB);
        wait_drain("t2a");
        ack_pulse();
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 10 * c_CPB);
        wait_drain("t2b");
        check("t2_no_overrun", n_ovr, 0);
        ack_pulse();

        // 3: framing error, line then held low
        ferr0 = n_ferr;
        send_frame(8'h81, 1'b0, 1'b0, 10 * c_CPB);
        busy0 = n_busy_rise;
        idle(3 * c_CPB);
        @(negedge clk);
        check("t3_ferr_cnt", n_ferr - ferr0, 1);
        check("t3_valid", {31'd0, data_valid}, 32'd0);
        check("t3_no_restart", n_busy_rise - busy0, 0);
        rx = 1'b1;
        idle(20);

        // 4: 4-cycle glitch
        busy0 = n_busy_rise; ferr0 = n_ferr; ovr0 = n_ovr;
        @(posedge clk); rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        @(negedge clk);
        check("t4_start_seen", n_busy_rise - busy0, 1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_valid", {31'd0, data_valid}, 32'd0);
        check("t4_pulses", (n_ferr - ferr0) + (n_ovr - ovr0), 0);

        // 5a: overrun
        ovr0 = n_ovr;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, 10 * c_CPB);
        send_frame(8'h22, 1'b1, 1'b0, 10 * c_CPB);
        idle(5);
        @(negedge clk);
        check("t5a_data", {24'd0, data}, 32'h11);
        check("t5a_valid", {31'd0, data_valid}, 32'd1);
        check("t5a_overrun", n_ovr - ovr0, 1);
        ack_pulse();
        idle(5);

        // 5b: ack on the stop-sample cycle
        ovr0 = n_ovr;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, 10 * c_CPB);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 1'b1, 10 * c_CPB);
        wait_drain("t5b");
        @(negedge clk);
        check("t5b_data", {24'd0, data}, 32'h22);
        check("t5b_valid", {31'd0, data_valid}, 32'd1);
        check("t5b_no_overrun", n_ovr - ovr0, 0);

        // 6: reset mid-frame, then clean frame
        send_frame(8'hFF, 1'b1, 1'b0, 4 * c_CPB);
        @(posedge clk);
        rst = 1'b0; rx = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_data", {24'd0, data}, 32'd0);
        check("t6_rst_valid", {31'd0, data_valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_pulses", {30'd0, frame_err, overrun}, 32'd0);
        rst = 1'b1;
        idle(20);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0, 10 * c_CPB);
        wait_drain("t6");
        @(negedge clk);
        check("t6_data", {24'd0, data}, 32'h0F);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
